// File: rtl/syzygy_dds_pkg.sv
// Shared types and constants for the DDS channel sequencer and its BRAM loader.
package syzygy_dds_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoad   = 2'd1,
    StSettle = 2'd2,
    StRun    = 2'd3
  } state_e;

  // BRAM byte addresses are word-aligned: this many low bits are always zero.
  localparam int unsigned AddrLsb = 2;

  // Two 12-bit samples packed per 32-bit waveform word.
  localparam int unsigned SampleW    = 12;
  localparam int unsigned Sample0Lsb = 0;
  localparam int unsigned Sample1Lsb = 16;

endpackage

// File: rtl/syzygy_dds_loader.sv
// Word counter, clamped length compare and registered BRAM write port for one waveform load.
module syzygy_dds_loader
  import syzygy_dds_pkg::*;
#(
  parameter int unsigned MEM_SIZE_BITS = 12
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_load_go,
  input  logic [MEM_SIZE_BITS:0]   i_load_len,
  input  logic                     i_active,
  input  logic                     i_wr_valid,
  input  logic [31:0]              i_wr_data,
  output logic                     o_len_zero,
  output logic                     o_last,
  output logic                     o_bram_we,
  output logic [31:0]              o_bram_addr,
  output logic [31:0]              o_bram_din,
  output logic                     o_load_done
);

  localparam int unsigned LenW = MEM_SIZE_BITS + 1;
  localparam logic [LenW-1:0] MaxLen = LenW'(1) << MEM_SIZE_BITS;

  logic [LenW-1:0] w_len_clamp;
  logic [LenW-1:0] r_len;
  logic [LenW-1:0] r_cnt;
  logic            w_fire;
  logic            r_we;
  logic [31:0]     r_addr;
  logic [31:0]     r_din;
  logic            r_load_done;

  assign w_len_clamp = (i_load_len > MaxLen) ? MaxLen : i_load_len;
  assign o_len_zero  = (w_len_clamp == '0);
  assign w_fire      = i_active & i_wr_valid;
  // r_len is never zero while active: zero-length loads never enter LOAD.
  assign o_last      = w_fire && (r_cnt == r_len - LenW'(1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_len       <= '0;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_din       <= '0;
      r_load_done <= 1'b0;
    end else begin
      r_we        <= w_fire;
      r_load_done <= o_last | (i_load_go & o_len_zero);
      if (i_load_go) begin
        r_cnt <= '0;
        r_len <= w_len_clamp;
      end else if (w_fire) begin
        r_cnt  <= r_cnt + LenW'(1);
        r_addr <= 32'({r_cnt[MEM_SIZE_BITS-1:0], {AddrLsb{1'b0}}});
        r_din  <= i_wr_data;
      end
    end
  end

  assign o_bram_we   = r_we;
  assign o_bram_addr = r_addr;
  assign o_bram_din  = r_din;
  assign o_load_done = r_load_done;

endmodule

// File: rtl/syzygy_dds_ctrl.sv
// Per-channel sequencer: loads a waveform into BRAM, then settles and runs the DDS reader.
module syzygy_dds_ctrl
  import syzygy_dds_pkg::*;
#(
  parameter int unsigned MEM_SIZE_BITS = 12,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_load_req,
  input  logic [MEM_SIZE_BITS:0] i_load_len,
  input  logic                   i_start,
  input  logic                   i_stop,
  input  logic [15:0]            i_rate_in,
  input  logic                   i_wr_valid,
  input  logic [31:0]            i_wr_data,
  output logic                   o_wr_ready,
  output logic                   o_bram_we,
  output logic [31:0]            o_bram_addr,
  output logic [31:0]            o_bram_din,
  output logic                   o_dds_reset,
  output logic [15:0]            o_dds_rate,
  output logic                   o_running,
  output logic                   o_busy,
  output logic                   o_load_done
);

  localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_e             r_state, w_state_d;
  logic [SettleW-1:0] r_settle_cnt, w_settle_cnt_d;
  logic [15:0]        r_rate;
  logic               r_wr_ready, r_dds_reset, r_running, r_busy;
  logic               w_load_go, w_rate_load, w_len_zero, w_last, w_settle_done;

  assign w_settle_done = (32'(r_settle_cnt) + 32'd1 >= SETTLE_CYCLES);

  always_comb begin
    w_state_d      = r_state;
    w_settle_cnt_d = r_settle_cnt;
    w_load_go      = 1'b0;
    w_rate_load    = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_load_req) begin
          w_load_go = 1'b1;
          w_state_d = w_len_zero ? StIdle : StLoad;
        end else if (i_start) begin
          w_rate_load    = 1'b1;
          w_settle_cnt_d = '0;
          w_state_d      = StSettle;
        end
      end
      StLoad: begin
        if (w_last) w_state_d = StIdle;
      end
      StSettle: begin
        if (i_stop) begin
          w_state_d = StIdle;
        end else if (w_settle_done) begin
          w_state_d = StRun;
        end else begin
          w_settle_cnt_d = r_settle_cnt + SettleW'(1);
        end
      end
      StRun: begin
        if (i_stop) begin
          w_state_d = StIdle;
        end else if (i_load_req) begin
          w_load_go = 1'b1;
          w_state_d = w_len_zero ? StIdle : StLoad;
        end else if (i_start) begin
          w_rate_load    = 1'b1;
          w_settle_cnt_d = '0;
          w_state_d      = StSettle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Status outputs are registered from the next state so they line up with the state change.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_settle_cnt <= '0;
      r_rate       <= '0;
      r_wr_ready   <= 1'b0;
      r_dds_reset  <= 1'b1;
      r_running    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_settle_cnt <= w_settle_cnt_d;
      r_wr_ready   <= (w_state_d == StLoad);
      r_dds_reset  <= (w_state_d != StRun);
      r_running    <= (w_state_d == StRun);
      r_busy       <= (w_state_d == StLoad) || (w_state_d == StSettle);
      if (w_rate_load) r_rate <= i_rate_in;
    end
  end

  syzygy_dds_loader #(
    .MEM_SIZE_BITS(MEM_SIZE_BITS)
  ) u_loader (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load_go  (w_load_go),
    .i_load_len (i_load_len),
    .i_active   (r_state == StLoad),
    .i_wr_valid (i_wr_valid),
    .i_wr_data  (i_wr_data),
    .o_len_zero (w_len_zero),
    .o_last     (w_last),
    .o_bram_we  (o_bram_we),
    .o_bram_addr(o_bram_addr),
    .o_bram_din (o_bram_din),
    .o_load_done(o_load_done)
  );

  assign o_wr_ready  = r_wr_ready;
  assign o_dds_reset = r_dds_reset;
  assign o_dds_rate  = r_rate;
  assign o_running   = r_running;
  assign o_busy      = r_busy;

endmodule
